mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the 4096x16 main memory. Port 0 serves the CPU (fetch/operand/store), port 1 serves the loader/IO channel. The block grants one requester at a time and drives the memory's address, read, write and data lines from registered copies. It returns read data and a one-cycle acknowledge, and never asserts read and write together.

## Interface
Parameters:
- AW, 12, address width; memory depth 2**AW words
- DW, 16, data word width

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- p0_req  in  1  CPU request; held with command until p0_ack
- p0_we  in  1  CPU command: 1 write, 0 read
- p0_addr  in  AW  CPU word address
- p0_wdata  in  DW  CPU write data
- p0_ack  out  1  one-cycle completion pulse to CPU
- p0_rdata  out  DW  read data to CPU; valid while p0_ack=1, held afterwards
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as p0_*, for loader/IO port
- mem_adress  out  AW  memory address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_indata  out  DW  memory write data
- mem_outdata  in  DW  memory read data, combinational from mem_adress
- busy  out  1  1 whenever state is not IDLE

## Operation
- States: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - Sample p0_req/p1_req at the rising edge.
  - If any request is present, pick the winner.
  - Latch the winner's we/addr/wdata into cmd_we/cmd_addr/cmd_wdata, record grant id, go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_adress=cmd_addr and mem_indata=cmd_wdata, all registered, so they are stable for the whole cycle.
  - Read command: mem_read=1. Write command: mem_write=1.
  - At the end of the cycle, a read captures mem_outdata into the winner's rdata register.
  - Go to DONE.
- DONE (one cycle):
  - Winner's ack=1; mem_read=mem_write=0.
  - Requests are not sampled.
  - Go to IDLE.
- Requester rule: drop req at the edge that ends ack. A req still high in IDLE is serviced as a new access.
- Arbitration, fixed mode: p0 wins whenever both ports request.
- Each pN_rdata changes only on a read completing on that port; otherwise it holds.
- mem_read & mem_write are never both 1. mem_adress holds its last value in IDLE/DONE.
- Reset values: state=IDLE, all acks=0, mem_read=mem_write=0, mem_adress=0, mem_indata=0, p0_rdata=p1_rdata=0, busy=0, last_grant=1.
- Reset asserted mid-ACCESS:
  - Strobes drop immediately (asynchronous).
  - A write in flight leaves the content at that address undefined.
  - No ack is issued.

## Timing
- Request sampled at edge N; memory strobe active in cycle N..N+1; ack high in cycle N+1..N+2.
- Next sample is at edge N+3.
- Throughput: one access per 3 cycles. A losing requester waits 3 cycles per preceding grant.
- Read data is captured at edge N+2 and valid with ack.

## Configuration
- MEM_ARB_RR_EN undefined: fixed priority, p0 over p1.
- MEM_ARB_RR_EN defined: round-robin.
  - On simultaneous requests, the port not granted last (last_grant) wins.
  - last_grant updates on every grant.
  - Reset value of last_grant is 1, so p0 wins the first contention.
  - A single request is always granted regardless of last_grant.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, DONE)
  - AW/DW default constants
  - port-id constants P_CPU=0, P_IO=1
- One sub-module, mem_arb_pick: combinational winner selection from req vector, last_grant and the RR mode bit.

## Test plan
- Reset, then p0 write addr 0x005 data 0xA5A5 → mem_write=1 for exactly one cycle with mem_adress=0x005, mem_indata=0xA5A5; p0_ack pulses at the 3rd cycle.
- p1 read 0x005 → p1_rdata=0xA5A5 with p1_ack; p0_rdata unchanged; mem_read=1 one cycle, mem_write=0 throughout.
- Both ports read simultaneously, fixed mode → p0 acked first, p1 acked 3 cycles later. Under MEM_ARB_RR_EN with both held for 4 accesses → grants alternate p0,p1,p0,p1.
- p0 holds req through ack for two transactions, addresses 0xFFF then 0x000 → two separate accesses; wrap addresses are correct; no double ack.
- rst_n low during ACCESS → mem_write, acks and busy go to 0 immediately; after release, state is IDLE and the next request completes normally.
- Random mixed traffic for 10k cycles against a memory model → mem_read&mem_write never both 1; every req gets exactly one ack; read data matches the model.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter: default address and
// data widths, the port identifiers used as grant ids, and the sequencer
// state encoding.
// Ports: none (package).
package mem_arb_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 16;

    // Grant ids: CPU port and loader/IO port.
    localparam logic P_CPU = 1'b0;
    localparam logic P_IO  = 1'b1;

    // Sequencer states.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE   = 2'b00;
    localparam arb_state_t ST_ACCESS = 2'b01;
    localparam arb_state_t ST_DONE   = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational winner selection between the CPU port and the IO port.
// Ports:
//   req        in  2  request vector, bit 0 = CPU, bit 1 = IO
//   last_grant in  1  port granted most recently
//   rr_en      in  1  1 = round-robin on contention, 0 = CPU always wins
//   valid      out 1  at least one request present
//   winner     out 1  selected port id (P_CPU / P_IO)
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic       valid,
    output logic       winner
);

    // Winner selection; a lone request always wins, contention goes to the CPU
    // or, in round-robin mode, to the port that did not win last time.
    always_comb begin
        valid  = req[0] | req[1];
        winner = P_CPU;
        if (req[0] && req[1]) begin
            if (rr_en) begin
                winner = ~last_grant;
            end else begin
                winner = P_CPU;
            end
        end else if (req[1]) begin
            winner = P_IO;
        end else begin
            winner = P_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter/sequencer in front of the main memory. One access takes
// three cycles: IDLE (sample + grant), ACCESS (strobe), DONE (ack).
// Configuration: define MEM_ARB_RR_EN for round-robin arbitration on
// contention; undefined gives fixed priority with the CPU port winning.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   p0_req/we/addr/wdata       CPU command, held until p0_ack
//   p0_ack, p0_rdata           CPU completion pulse and read data
//   p1_*                       same for the loader/IO port
//   mem_adress, mem_indata     registered memory address / write data
//   mem_read, mem_write        registered memory strobes (never both set)
//   mem_outdata                memory read data (combinational from address)
//   busy                       high whenever the sequencer is not idle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_adress,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_indata,
    input  logic [DW-1:0] mem_outdata,
    output logic          busy
);

`ifdef MEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_t    state_r;
    logic          cmd_we_r;
    logic [AW-1:0] cmd_addr_r;
    logic [DW-1:0] cmd_wdata_r;
    // Updated on every grant, so it doubles as the grant id of the
    // transaction in flight.
    logic          last_grant_r;

    logic          pick_valid_s;
    logic          pick_winner_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    mem_arb_pick u_pick (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant_r),
        .rr_en      (RR_EN),
        .valid      (pick_valid_s),
        .winner     (pick_winner_s)
    );

    // The command registers feed the memory directly, so address and write
    // data stay stable through ACCESS and hold their value in IDLE/DONE.
    assign mem_adress = cmd_addr_r;
    assign mem_indata = cmd_wdata_r;

    // Route the winning port's command to the command registers.
    always_comb begin
        if (pick_winner_s == P_IO) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Sequencer: grant in IDLE, strobe in ACCESS, acknowledge in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cmd_we_r     <= 1'b0;
            cmd_addr_r   <= {AW{1'b0}};
            cmd_wdata_r  <= {DW{1'b0}};
            last_grant_r <= 1'b1;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            p0_ack       <= 1'b0;
            p1_ack       <= 1'b0;
            p0_rdata     <= {DW{1'b0}};
            p1_rdata     <= {DW{1'b0}};
            busy         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        cmd_we_r     <= sel_we_s;
                        cmd_addr_r   <= sel_addr_s;
                        cmd_wdata_r  <= sel_wdata_s;
                        last_grant_r <= pick_winner_s;
                        mem_read     <= ~sel_we_s;
                        mem_write    <= sel_we_s;
                        busy         <= 1'b1;
                        state_r      <= ST_ACCESS;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (!cmd_we_r) begin
                        if (last_grant_r == P_IO) begin
                            p1_rdata <= mem_outdata;
                        end else begin
                            p0_rdata <= mem_outdata;
                        end
                    end
                    p0_ack  <= (last_grant_r == P_CPU);
                    p1_ack  <= (last_grant_r == P_IO);
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    p0_ack  <= 1'b0;
                    p1_ack  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    p0_ack    <= 1'b0;
                    p1_ack    <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// two-port traffic, checked cycle by cycle against a transaction-level model
// (one grant per three cycles, priority rule, shadow memory).
// Honours MEM_ARB_RR_EN the same way as the design.
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_v;
    logic        we_v    [2];
    logic [11:0] addr_v  [2];
    logic [15:0] wdata_v [2];
    logic        p0_ack, p1_ack, mem_read, mem_write, busy;
    logic [15:0] p0_rdata, p1_rdata, mem_indata, mem_outdata;
    logic [11:0] mem_adress;

    // Environment memory seen by the DUT.
    logic [15:0] env_mem [0:4095];

    // Reference model state.
    logic [15:0] ref_mem   [0:4095];
    bit          ref_known [0:4095];
    int          e, next_sample, strobe_edge, g_port, last_grant;
    logic        g_we;
    logic [11:0] g_addr;
    logic [15:0] g_wdata, g_rexp;
    bit          g_rknown;
    logic [15:0] exp_rd [2];
    bit          exp_rd_known [2];
    int          issued [2];
    int          acked  [2];
    int          ack_log [$];
    cmd_t        q0 [$];
    cmd_t        q1 [$];
    int          n_tests, n_fail;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) env_mem[mem_adress] <= mem_indata;
    end
    assign mem_outdata = env_mem[mem_adress];

    mem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p0_req      (req_v[0]),
        .p0_we       (we_v[0]),
        .p0_addr     (addr_v[0]),
        .p0_wdata    (wdata_v[0]),
        .p0_ack      (p0_ack),
        .p0_rdata    (p0_rdata),
        .p1_req      (req_v[1]),
        .p1_we       (we_v[1]),
        .p1_addr     (addr_v[1]),
        .p1_wdata    (wdata_v[1]),
        .p1_ack      (p1_ack),
        .p1_rdata    (p1_rdata),
        .mem_adress  (mem_adress),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_indata  (mem_indata),
        .mem_outdata (mem_outdata),
        .busy        (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic cmd_t mk(input logic we, input logic [11:0] addr, input logic [15:0] wdata);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata;
        return c;
    endfunction

    // Arbitration rule at the transaction level.
    function automatic int pick(input logic r0, input logic r1, input int lg);
        if (r0 && r1) begin
`ifdef MEM_ARB_RR_EN
            return 1 - lg;
`else
            return 0;
`endif
        end
        if (r1) return 1;
        return 0;
    endfunction

    // Requester behaviour: present the next queued command; on ack either
    // present the next one (req held) or drop req.
    task automatic req_update(input int p, input logic got_ack);
        cmd_t c;
        bit   have;
        have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (got_ack || !req_v[p]) begin
            if (have) begin
                if (p == 0) c = q0.pop_front();
                else        c = q1.pop_front();
                we_v[p] = c.we; addr_v[p] = c.addr; wdata_v[p] = c.wdata;
                req_v[p] = 1'b1;
                issued[p]++;
            end else begin
                req_v[p] = 1'b0;
            end
        end
    endtask

    task automatic step();
        bit strobe, ack;
        int w;
        @(posedge clk);
        e++;
        if (e >= next_sample && (req_v[0] || req_v[1])) begin
            w = pick(req_v[0], req_v[1], last_grant);
            last_grant = w;
            g_port = w; g_we = we_v[w]; g_addr = addr_v[w]; g_wdata = wdata_v[w];
            strobe_edge = e;
            next_sample = e + 3;
            if (g_we) begin
                ref_mem[g_addr] = g_wdata;
                ref_known[g_addr] = 1'b1;
            end else begin
                g_rexp = ref_mem[g_addr];
                g_rknown = ref_known[g_addr];
            end
        end
        #1;
        strobe = (e == strobe_edge);
        ack = (e == strobe_edge + 1);
        check_val("strobe_excl", 32'(mem_read & mem_write), 32'd0);
        check_val("mem_read", 32'(mem_read), 32'(strobe && !g_we));
        check_val("mem_write", 32'(mem_write), 32'(strobe && g_we));
        check_val("busy", 32'(busy), 32'(strobe || ack));
        check_val("p0_ack", 32'(p0_ack), 32'(ack && g_port == 0));
        check_val("p1_ack", 32'(p1_ack), 32'(ack && g_port == 1));
        if (strobe) begin
            check_val("mem_adress", 32'(mem_adress), 32'(g_addr));
            if (g_we) check_val("mem_indata", 32'(mem_indata), 32'(g_wdata));
        end
        if (ack && !g_we) begin
            exp_rd[g_port] = g_rexp;
            exp_rd_known[g_port] = g_rknown;
        end
        if (exp_rd_known[0]) check_val("p0_rdata", 32'(p0_rdata), 32'(exp_rd[0]));
        if (exp_rd_known[1]) check_val("p1_rdata", 32'(p1_rdata), 32'(exp_rd[1]));
        if (p0_ack) begin acked[0]++; ack_log.push_back(0); end
        if (p1_ack) begin acked[1]++; ack_log.push_back(1); end
        req_update(0, p0_ack);
        req_update(1, p1_ack);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        check_val({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        check_val({tag, "_p0_ack"}, 32'(p0_ack), 32'd0);
        check_val({tag, "_p1_ack"}, 32'(p1_ack), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_mem_adress"}, 32'(mem_adress), 32'd0);
        check_val({tag, "_mem_indata"}, 32'(mem_indata), 32'd0);
        check_val({tag, "_p0_rdata"}, 32'(p0_rdata), 32'd0);
        check_val({tag, "_p1_rdata"}, 32'(p1_rdata), 32'd0);
    endtask

    // Assert reset in the middle of the current cycle and hold it for two edges.
    task automatic reset_mid_cycle(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        req_v = 2'b00;
        q0.delete();
        q1.delete();
        if (strobe_edge == e || strobe_edge == e - 1) begin
            if (g_we) ref_known[g_addr] = 1'b0;
            issued[g_port]--;
        end
        strobe_edge = -10;
        last_grant = 1;
        exp_rd[0] = 16'h0000; exp_rd[1] = 16'h0000;
        exp_rd_known[0] = 1'b1; exp_rd_known[1] = 1'b1;
        @(posedge clk); e++;
        @(posedge clk); e++;
        #2;
        rst_n = 1'b1;
        next_sample = e + 1;
    endtask

    initial begin
        int exp_order [4];
        cmd_t c;
        n_tests = 0; n_fail = 0;
        e = 0; next_sample = 0; strobe_edge = -10; last_grant = 1; g_port = 0;
        g_we = 1'b0; g_addr = 12'h000; g_wdata = 16'h0000; g_rexp = 16'h0000; g_rknown = 1'b0;
        issued[0] = 0; issued[1] = 0; acked[0] = 0; acked[1] = 0;
        req_v = 2'b00;
        for (int p = 0; p < 2; p++) begin
            we_v[p] = 1'b0; addr_v[p] = 12'h000; wdata_v[p] = 16'h0000;
        end

        // Power-on reset.
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        reset_mid_cycle("por");

        // CPU write 0x005 <- 0xA5A5.
        q0.push_back(mk(1'b1, 12'h005, 16'hA5A5));
        run(6);

        // IO read of the same word; CPU read data must not move.
        q1.push_back(mk(1'b0, 12'h005, 16'h0000));
        run(6);
        check_val("io_read_data", 32'(p1_rdata), 32'h0000A5A5);
        check_val("cpu_rdata_hold", 32'(p0_rdata), 32'h00000000);

        // Both ports hold requests for two reads each.
        ack_log.delete();
        q0.push_back(mk(1'b0, 12'h005, 16'h0000));
        q0.push_back(mk(1'b0, 12'h005, 16'h0000));
        q1.push_back(mk(1'b0, 12'h005, 16'h0000));
        q1.push_back(mk(1'b0, 12'h005, 16'h0000));
        run(16);
`ifdef MEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        check_val("contention_count", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_log.size()) check_val("contention_order", 32'(ack_log[i]), 32'(exp_order[i]));
        end

        // CPU holds req through ack: address range ends, then read back.
        q0.push_back(mk(1'b1, 12'hFFF, 16'h1234));
        q0.push_back(mk(1'b1, 12'h000, 16'h5678));
        q0.push_back(mk(1'b0, 12'hFFF, 16'h0000));
        q0.push_back(mk(1'b0, 12'h000, 16'h0000));
        run(16);
        check_val("wrap_read_data", 32'(p0_rdata), 32'h00005678);

        // Reset during the ACCESS cycle of a write.
        q0.push_back(mk(1'b1, 12'h123, 16'hBEEF));
        for (int i = 0; i < 6 && strobe_edge != e; i++) step();
        check_val("reach_access", 32'(strobe_edge == e), 32'd1);
        reset_mid_cycle("mid_rst");
        q1.push_back(mk(1'b0, 12'h005, 16'h0000));
        run(6);
        check_val("post_rst_read", 32'(p1_rdata), 32'h0000A5A5);

        // Random mixed traffic.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0) begin
                c = mk(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 16'($urandom));
                if ($urandom_range(0, 7) == 0) c.addr = 12'hFFF;
                q0.push_back(c);
            end
            if (q1.size() == 0 && $urandom_range(0, 2) == 0) begin
                c = mk(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 16'($urandom));
                q1.push_back(c);
            end
            step();
        end
        run(30);
        check_val("p0_all_acked", 32'(acked[0]), 32'(issued[0]));
        check_val("p1_all_acked", 32'(acked[1]), 32'(issued[1]));
        check_val("p0_idle_end", 32'(req_v[0]), 32'd0);
        check_val("p1_idle_end", 32'(req_v[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
